// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes and console command codes.
package alu_pkg;
  typedef enum logic [2:0] {
    F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOT, F_SLT, F_PASS
  } f_e;
  typedef enum logic [1:0] {
    CMD_F, CMD_A, CMD_B, CMD_EXEC
  } cmd_e;
endpackage

// File: rtl/alu.sv
// alu: combinational WIDTH-bit ALU with zero flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_f,
  output logic [WIDTH-1:0] o_y,
  output logic             o_z
);
  always_comb begin
    o_y = '0;
    case (i_f)
      F_ADD:  o_y = i_a + i_b;
      F_SUB:  o_y = i_a - i_b;
      F_AND:  o_y = i_a & i_b;
      F_OR:   o_y = i_a | i_b;
      F_XOR:  o_y = i_a ^ i_b;
      F_NOT:  o_y = ~i_a;
      F_SLT:  o_y = {{(WIDTH-1){1'b0}}, i_a < i_b};
      default: o_y = i_b;
    endcase
  end
  assign o_z = o_y == '0;
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button, debounces it and emits a one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic pulse
);
  localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  logic          r_s1, r_s2, r_lvl, r_lvl_d, r_pulse;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_lvl_d <= r_lvl;
      r_pulse <= r_lvl & ~r_lvl_d;
      if (r_s2 == r_lvl) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE - 1)) begin
        r_lvl <= r_s2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  assign pulse = r_pulse;
endmodule

// File: rtl/alu_console.sv
// alu_console: switch/button operator console driving an ALU with accumulate and step count.
module alu_console
  import alu_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int DEBOUNCE = 16,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH+1:0] sw,
  output logic [WIDTH+1:0] led,
  output logic [CNT_W-1:0] steps
);
  logic [WIDTH-1:0] r_a, r_b, w_y, w_data;
  logic [2:0]       r_f;
  logic [CNT_W-1:0] r_steps;
  logic             w_pulse, w_z;
  cmd_e             w_cmd;
  assign w_cmd  = cmd_e'(sw[WIDTH+1:WIDTH]);
  assign w_data = sw[WIDTH-1:0];
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (.clk(clk), .rstn(rstn), .raw(en), .pulse(w_pulse));
  alu #(.WIDTH(WIDTH)) u_alu (.i_a(r_a), .i_b(r_b), .i_f(r_f), .o_y(w_y), .o_z(w_z));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_a     <= '0;
      r_b     <= '0;
      r_f     <= '0;
      r_steps <= '0;
    end else if (w_pulse)
      case (w_cmd)
        CMD_F: r_f <= sw[2:0];
        CMD_A: r_a <= w_data;
        CMD_B: r_b <= w_data;
        default:
          if (w_data[0]) begin
            r_a     <= '0;
            r_b     <= '0;
            r_f     <= '0;
            r_steps <= '0;
          end else begin
            r_a     <= w_y;
            r_steps <= r_steps + 1'b1;
          end
      endcase
  assign led   = {w_z, r_steps[0], w_y};
  assign steps = r_steps;
endmodule

// File: tb/tb_alu_console.sv
// tb_alu_console: directed and randomized checks of alu_console against an arithmetic model.
module tb_alu_console;
  localparam int W = 6, D = 16, CW = 4, SWW = W + 2, MASK = (1 << W) - 1;
  logic           clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic [SWW-1:0] sw = '0;
  logic [SWW-1:0] led;
  logic [CW-1:0]  steps;
  int n_cmp = 0, n_bad = 0;
  int m_a = 0, m_b = 0, m_f = 0, m_st = 0;

  alu_console #(.WIDTH(W), .DEBOUNCE(D), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .sw(sw), .led(led), .steps(steps));

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_y(int a, int b, int f);
    int r;
    case (f)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = (a < b) ? 1 : 0;
      default: r = b;
    endcase
    return r & MASK;
  endfunction

  function automatic logic [31:0] exp_led();
    int y;
    y = ref_y(m_a, m_b, m_f);
    return ((y == 0 ? 1 : 0) << (W + 1)) | ((m_st & 1) << W) | y;
  endfunction

  task automatic chk_model(string tag);
    chk({tag, " led"}, led, exp_led());
    chk({tag, " steps"}, steps, m_st);
  endtask

  task automatic apply(int cmd, int data);
    case (cmd)
      0: m_f = data & 7;
      1: m_a = data;
      2: m_b = data;
      default:
        if (data & 1) begin
          m_a = 0; m_b = 0; m_f = 0; m_st = 0;
        end else begin
          m_a  = ref_y(m_a, m_b, m_f);
          m_st = (m_st + 1) % (1 << CW);
        end
    endcase
  endtask

  task automatic press(int cmd, int data);
    sw = SWW'((cmd << W) | data);
    en = 1'b1;
    tick(D + 8);
    en = 1'b0;
    tick(D + 8);
    apply(cmd, data);
  endtask

  initial begin
    tick(3);
    chk("reset led", led, 32'h80);
    chk("reset steps", steps, 0);
    rstn = 1'b1;
    tick(2);
    press(1, 5); press(2, 3); press(0, 0);
    chk("load led", led, 8);
    chk("load steps", steps, 0);
    chk_model("load");
    for (int i = 0; i < 3; i++) begin
      press(3, 0);
      chk_model("exec");
    end
    chk("exec3 led", led, (1 << W) | 17);
    chk("exec3 steps", steps, 3);
    for (int i = 0; i < 13; i++) press(3, 0);
    chk("wrap led", led, 56);
    chk("wrap steps", steps, 0);
    chk_model("wrap");
    // glitches shorter than the debounce window must not load a
    sw = SWW'((1 << W) | 40);
    en = 1'b1; tick(10); en = 1'b0; tick(10);
    en = 1'b1; tick(15); en = 1'b0; tick(30);
    chk_model("glitch");
    en = 1'b1;
    tick(D + 3);
    chk_model("pre-update");
    tick(1);
    apply(1, 40);
    chk_model("update edge");
    tick(40 - (D + 4));
    en = 1'b0;
    tick(D + 8);
    chk_model("long press");
    press(1, 7); press(2, 7); press(0, 1);
    chk("sub zero led", led, 32'h80);
    press(1, 2);
    chk("sub neg led", led, 59);
    chk_model("sub");
    // reset lands mid-press; the still-held button is a fresh press
    sw = SWW'(3 << W);
    en = 1'b1;
    tick(8);
    rstn = 1'b0;
    #1;
    chk("async reset led", led, 32'h80);
    chk("async reset steps", steps, 0);
    tick(2);
    chk("in reset led", led, 32'h80);
    rstn = 1'b1;
    m_a = 0; m_b = 0; m_f = 0; m_st = 0;
    tick(D + 3);
    chk("post-reset pre steps", steps, 0);
    tick(1);
    apply(3, 0);
    chk_model("post-reset pulse");
    tick(40);
    chk("post-reset single steps", steps, 1);
    en = 1'b0;
    tick(D + 8);
    chk_model("post-reset release");
    for (int i = 0; i < 40; i++) begin
      int c, d;
      c = $urandom_range(0, 3);
      d = $urandom_range(0, MASK);
      if (c == 3 && (d & 1) != 0 && $urandom_range(0, 3) != 0) d = d & ~1;
      press(c, d);
      chk_model("rand");
    end
    press(1, 9); press(2, 4); press(0, 3); press(3, 0);
    chk_model("pre-clear");
    press(3, 1);
    chk("clear led", led, 32'h80);
    chk("clear steps", steps, 0);
    chk_model("clear");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_console.md
Name: alu_console

Overview:
- Board-level operator console for the parametrised ALU.
- Debounces the push button and derives a single-cycle command pulse from it.
- Decodes switch commands that load the function code and operands A/B, or execute an accumulate step (A <= Y).
- Drives LEDs with the live result, zero flag and a step counter indicator. Replaces the fixed 6-bit, non-debounced, reset-less console.

Parameters:
WIDTH, 6, operand/result width; also sets switch and LED widths
DEBOUNCE, 16, clk cycles the synchronised button must be stable before a level change is accepted (>=1)
CNT_W, 4, width of the execute-step counter

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
en  in  1  raw push button, asynchronous to clk, active-high
sw  in  WIDTH+2  sw[WIDTH+1:WIDTH] = command, sw[WIDTH-1:0] = data
led  out  WIDTH+2  {z, odd, y}: z = ALU zero flag, odd = step counter LSB, y = ALU result
steps  out  CNT_W  number of execute commands since reset or clear (wraps)

Behaviour:
- Reset is asynchronous and active-low. While rstn = 0: a = 0, b = 0, f = 0, steps = 0, all synchroniser and debounce state = 0, debounced level = 0, pulse = 0. Resulting led = {1, 0, 0} (0+0 = 0, so z = 1).
- Input path: en passes through a 2-FF synchroniser (s2). Debounce counter resets to 0 whenever s2 equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE-1, the debounced level takes s2 and the counter clears.
- Pulse: asserted for exactly one cycle on the 0->1 transition of the debounced level. Release (1->0) produces no pulse.
- Latency: a clean press held steady produces its pulse DEBOUNCE+3 cycles after en rises. Register update lands on the following edge.
- Glitches shorter than DEBOUNCE cycles produce no pulse.
- Command decode, on a pulse only (sw sampled in the pulse cycle):
  - 0: f <= sw[2:0]; a and b unchanged.
  - 1: a <= sw[WIDTH-1:0].
  - 2: b <= sw[WIDTH-1:0].
  - 3, data[0] = 0: execute. a <= y (current combinational result) and steps <= steps+1, modulo 2^CNT_W.
  - 3, data[0] = 1: clear. a, b, f, steps <= 0.
- No pulse means all registers hold.
- ALU (combinational, WIDTH bits), f encoding:
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SLT (y = 1 if a<b unsigned, else 0); 7 PASS b.
  - Results truncated to WIDTH bits; carries/borrows discarded.
  - z = (y == 0).
- led and steps are combinational from registers; they update the cycle after the register edge.
- rstn asserted mid-debounce discards the pending press: no pulse after release of reset until a fresh stable press.
- Button held across reset deassertion: this counts as a new press and yields one pulse after DEBOUNCE+3 cycles.

Decomposition:
- Shared package alu_pkg:
  - f-code constants: F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOT, F_SLT, F_PASS.
  - Command constants: CMD_F, CMD_A, CMD_B, CMD_EXEC.
- One sub-module, btn_debounce (params DEBOUNCE; ports clk, rstn, raw, pulse). It holds the synchroniser, stability counter and rising-edge pulse.
- The ALU instance uses the existing parametrised alu with WIDTH.

Test Plan:
- Reset, then load: rstn low then high; press with sw = {2'd1, 6'd5}, then {2'd2, 6'd3}, then {2'd0, 3'd0}. Required: led = {0, 0, 6'd8}; steps = 0.
- Accumulate wrap: a = 5, b = 3, f = ADD; issue EXEC 3 times. Required: a goes 8, 11, 14; led y = 17; steps = 3; odd = 1. Then 13 more EXECs. Required: steps wraps to 0; y = (5+3*17) mod 64 = 56.
- Debounce rejection: with DEBOUNCE = 16, en high for 10 cycles, low 10, high 15, then low. Required: no register change. Then a 40-cycle press. Required: exactly one update, DEBOUNCE+4 cycles after the rise.
- Zero and SUB: a = 7, b = 7, f = SUB. Required: y = 0, z = 1. Then a = 2. Required: y = 6'd59, z = 0.
- Reset mid-press: assert rstn for 2 cycles at cycle 8 of a held press, release while en is still high. Required: all registers 0 and led = {1, 0, 0}; exactly one pulse DEBOUNCE+3 cycles after reset release.
- Clear: after a non-zero state, sw = {2'd3, 6'd1} with a press. Required: a = b = f = steps = 0; led = {1, 0, 0}.
